// File: rtl/bullet_pool_control_if.sv
// Handshake bundle between the bullet pool, its input sources and the draw logic.
interface bullet_pool_control_if #(
   parameter int unsigned NUM_BULLETS = 4
) ();
   logic                       load_level;
   logic                       play;
   logic                       fire;
   logic [7:0]                 player_x;
   logic [6:0]                 player_y;
   logic [NUM_BULLETS-1:0]     hit_mask;
   logic [8*NUM_BULLETS-1:0]   bullet_x;
   logic [7*NUM_BULLETS-1:0]   bullet_y;
   logic [NUM_BULLETS-1:0]     active;
   logic                       move;
   logic                       launched;

   // Game-side driver of the pool
   modport master (
      output load_level, play, fire, player_x, player_y, hit_mask,
      input  bullet_x, bullet_y, active, move, launched
   );

   // The bullet pool itself
   modport slave (
      input  load_level, play, fire, player_x, player_y, hit_mask,
      output bullet_x, bullet_y, active, move, launched
   );
endinterface

// File: rtl/bullet_pool_control.sv
// Pool of independent upward-moving bullets with fire cooldown, optional auto-fire
// and per-slot hit clearing. All outputs are registered.
module bullet_pool_control #(
   parameter int unsigned NUM_BULLETS = 4,
   parameter int unsigned RATE_DIV    = 500000,
   parameter int unsigned COOLDOWN    = 250000,
   parameter bit          AUTO_FIRE   = 1'b0
) (
   input logic                     clk,
   input logic                     resetn,
   bullet_pool_control_if.slave    bus_io
);

   localparam int unsigned CntW = $clog2(RATE_DIV);
   localparam int unsigned CdW  = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(RATE_DIV - 1);
   localparam logic [CdW-1:0]  CdLoad = CdW'(COOLDOWN);

   logic [NUM_BULLETS-1:0]        active_q, active_d;
   logic [NUM_BULLETS-1:0][7:0]   x_q, x_d;
   logic [NUM_BULLETS-1:0][6:0]   y_q, y_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic [CdW-1:0]                cd_q, cd_d;
   logic                          fire_q;
   logic                          move_q, move_d;
   logic                          launched_q, launched_d;

   logic                          clear;
   logic                          req;
   logic                          grant;
   logic                          step;
   logic [NUM_BULLETS-1:0]        launch_oh;

   assign clear = !resetn || bus_io.load_level;
   assign req   = AUTO_FIRE ? bus_io.fire : (bus_io.fire & ~fire_q);
   assign grant = req & bus_io.play & (cd_q == '0) & ~(&active_q);
   assign step  = bus_io.play & (|active_q) & (cnt_q == CntMax);

   // Lowest-index free slot receives the launch (one-hot, empty when no grant)
   always_comb begin
      logic taken;
      taken     = 1'b0;
      launch_oh = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (!active_q[i] && !taken) begin
            launch_oh[i] = grant;
            taken        = 1'b1;
         end
      end
   end

   // Next state for counters, slots and pulses; everything holds while play is low
   always_comb begin
      active_d   = active_q;
      x_d        = x_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      cd_d       = cd_q;
      move_d     = 1'b0;
      launched_d = 1'b0;
      if (bus_io.play) begin
         if (!(|active_q) || step) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         if (grant) begin
            cd_d = CdLoad;
         end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
         end
         move_d     = step;
         launched_d = grant;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            if (launch_oh[i]) begin
               // Slot was inactive, so neither hit nor step applies to it this cycle
               active_d[i] = 1'b1;
               x_d[i]      = bus_io.player_x + 8'd1;
               y_d[i]      = bus_io.player_y;
            end else if (bus_io.hit_mask[i] && active_q[i]) begin
               active_d[i] = 1'b0;
               x_d[i]      = '0;
               y_d[i]      = '0;
            end else if (step && active_q[i]) begin
               if (y_q[i] == '0) begin
                  active_d[i] = 1'b0;
                  x_d[i]      = '0;
               end else begin
                  y_d[i] = y_q[i] - 7'd1;
               end
            end
         end
      end
   end

   // State registers with synchronous reset / level reload
   always_ff @(posedge clk) begin
      if (clear) begin
         active_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         cd_q       <= '0;
         fire_q     <= 1'b0;
         move_q     <= 1'b0;
         launched_q <= 1'b0;
      end else begin
         active_q   <= active_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         cd_q       <= cd_d;
         // Tracked even while paused so a held button does not re-fire on resume
         fire_q     <= bus_io.fire;
         move_q     <= move_d;
         launched_q <= launched_d;
      end
   end

   assign bus_io.bullet_x = x_q;
   assign bus_io.bullet_y = y_q;
   assign bus_io.active   = active_q;
   assign bus_io.move     = move_q;
   assign bus_io.launched = launched_q;

endmodule

// File: tb/tb_bullet_pool_control.sv
// Directed bench: manual-fire pool (dut_a) and auto-fire pool (dut_b).
module tb_bullet_pool_control;

   logic clk = 1'b0;
   logic resetn_a;
   logic resetn_b;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   bullet_pool_control_if #(.NUM_BULLETS(3)) ifa ();
   bullet_pool_control_if #(.NUM_BULLETS(3)) ifb ();

   bullet_pool_control #(
      .NUM_BULLETS(3), .RATE_DIV(4), .COOLDOWN(8), .AUTO_FIRE(1'b0)
   ) dut_a (
      .clk    (clk),
      .resetn (resetn_a),
      .bus_io (ifa)
   );

   bullet_pool_control #(
      .NUM_BULLETS(3), .RATE_DIV(4), .COOLDOWN(8), .AUTO_FIRE(1'b1)
   ) dut_b (
      .clk    (clk),
      .resetn (resetn_b),
      .bus_io (ifb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn_a = 1'b0;
      resetn_b = 1'b0;
      ifa.load_level = 1'b0; ifa.play = 1'b1; ifa.fire = 1'b0;
      ifa.player_x = 8'd80;  ifa.player_y = 7'd115; ifa.hit_mask = 3'b000;
      ifb.load_level = 1'b0; ifb.play = 1'b0; ifb.fire = 1'b0;
      ifb.player_x = 8'd40;  ifb.player_y = 7'd100; ifb.hit_mask = 3'b000;

      // Reset
      tick();
      chk("rst_active", ifa.active, 0);
      chk("rst_x", ifa.bullet_x, 0);
      chk("rst_y", ifa.bullet_y, 0);
      chk("rst_move", ifa.move, 0);
      chk("rst_launched", ifa.launched, 0);
      chk("rst_b_active", ifb.active, 0);
      resetn_a = 1'b1;
      resetn_b = 1'b1;
      tick();

      // Single shot from (80,115)
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;
      chk("ss_launched", ifa.launched, 1);
      chk("ss_active", ifa.active, 3'b001);
      chk("ss_x0", ifa.bullet_x[7:0], 81);
      chk("ss_y0", ifa.bullet_y[6:0], 115);
      ticks(4);
      chk("ss_step1_y", ifa.bullet_y[6:0], 114);
      chk("ss_step1_move", ifa.move, 1);
      chk("ss_step1_x", ifa.bullet_x[7:0], 81);
      tick();
      chk("ss_move_pulse", ifa.move, 0);
      ticks(3);
      chk("ss_step2_y", ifa.bullet_y[6:0], 113);
      ticks(452);
      chk("ss_y_zero", ifa.bullet_y[6:0], 0);
      chk("ss_still_active", ifa.active, 3'b001);
      ticks(4);
      chk("ss_expired_active", ifa.active, 3'b000);
      chk("ss_expired_x", ifa.bullet_x[7:0], 0);
      chk("ss_expired_move", ifa.move, 1);

      // Cooldown: edge 3 cycles after first dropped, edge 9 cycles after accepted
      ifa.player_x = 8'd10; ifa.player_y = 7'd50;
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E0
      chk("cd_first_active", ifa.active, 3'b001);
      tick();                                                 // E1
      chk("cd_launched_pulse", ifa.launched, 0);
      tick();                                                 // E2
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E3
      chk("cd_blocked_launched", ifa.launched, 0);
      chk("cd_blocked_active", ifa.active, 3'b001);
      ticks(5);                                               // E8
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E9
      chk("cd_second_launched", ifa.launched, 1);
      chk("cd_second_active", ifa.active, 3'b011);
      chk("cd_slot1_x", ifa.bullet_x[15:8], 11);
      chk("cd_slot1_y", ifa.bullet_y[13:7], 50);
      chk("cd_slot0_y", ifa.bullet_y[6:0], 48);

      // Pool full, then hit frees slot1 which is reused by the next edge
      ifa.player_x = 8'd20; ifa.player_y = 7'd60;
      ticks(8);                                               // E17
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E18
      chk("pf_third_active", ifa.active, 3'b111);
      chk("pf_slot2_x", ifa.bullet_x[23:16], 21);
      chk("pf_slot2_y", ifa.bullet_y[20:14], 60);
      ticks(8);                                               // E26
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E27
      chk("pf_full_launched", ifa.launched, 0);
      chk("pf_full_active", ifa.active, 3'b111);
      ifa.hit_mask = 3'b010;
      ifa.player_x = 8'd30; ifa.player_y = 7'd70;
      tick();                                                 // E28
      ifa.hit_mask = 3'b000;
      chk("pf_hit_active", ifa.active, 3'b101);
      chk("pf_hit_x1", ifa.bullet_x[15:8], 0);
      chk("pf_hit_y1", ifa.bullet_y[13:7], 0);
      chk("pf_step_y0", ifa.bullet_y[6:0], 43);
      chk("pf_step_y2", ifa.bullet_y[20:14], 57);
      ifa.fire = 1'b1; tick(); ifa.fire = 1'b0;              // E29
      chk("pf_reuse_launched", ifa.launched, 1);
      chk("pf_reuse_active", ifa.active, 3'b111);
      chk("pf_reuse_x1", ifa.bullet_x[15:8], 31);
      chk("pf_reuse_y1", ifa.bullet_y[13:7], 70);

      // Hit on slot0 coinciding with a step
      ticks(2);                                               // E31
      ifa.hit_mask = 3'b001;
      tick();                                                 // E32
      ifa.hit_mask = 3'b000;
      chk("hs_active", ifa.active, 3'b110);
      chk("hs_x0", ifa.bullet_x[7:0], 0);
      chk("hs_y0", ifa.bullet_y[6:0], 0);
      chk("hs_y1", ifa.bullet_y[13:7], 69);
      chk("hs_y2", ifa.bullet_y[20:14], 56);
      chk("hs_move", ifa.move, 1);

      // Level reload clears the manual pool
      ifa.load_level = 1'b1; tick(); ifa.load_level = 1'b0;
      chk("ll_a_active", ifa.active, 3'b000);
      chk("ll_a_y", ifa.bullet_y, 0);

      // Auto-fire with button held
      ifb.play = 1'b1; ifb.fire = 1'b1;
      tick();                                                 // F0
      chk("af_first_launched", ifb.launched, 1);
      chk("af_first_active", ifb.active, 3'b001);
      chk("af_first_x", ifb.bullet_x[7:0], 41);
      ticks(8);                                               // F8
      chk("af_wait_active", ifb.active, 3'b001);
      chk("af_wait_launched", ifb.launched, 0);
      chk("af_wait_y0", ifb.bullet_y[6:0], 98);
      tick();                                                 // F9
      chk("af_second_active", ifb.active, 3'b011);
      chk("af_second_y1", ifb.bullet_y[13:7], 100);

      // Pause freezes positions and cooldown
      ifb.play = 1'b0;
      ticks(10);                                              // F19
      chk("pz_active", ifb.active, 3'b011);
      chk("pz_y0", ifb.bullet_y[6:0], 98);
      chk("pz_y1", ifb.bullet_y[13:7], 100);
      chk("pz_move", ifb.move, 0);
      chk("pz_launched", ifb.launched, 0);
      ifb.play = 1'b1;
      ticks(3);                                               // F22
      chk("pz_resume_move", ifb.move, 1);
      chk("pz_resume_y0", ifb.bullet_y[6:0], 97);
      chk("pz_resume_y1", ifb.bullet_y[13:7], 99);
      ticks(5);                                               // F27
      chk("af_cd_hold_active", ifb.active, 3'b011);
      tick();                                                 // F28
      chk("af_third_active", ifb.active, 3'b111);
      chk("af_third_launched", ifb.launched, 1);
      chk("af_third_x", ifb.bullet_x[23:16], 41);
      ticks(9);                                               // F37
      chk("af_full_launched", ifb.launched, 0);
      chk("af_full_active", ifb.active, 3'b111);

      ifb.load_level = 1'b1; tick(); ifb.load_level = 1'b0;
      ifb.fire = 1'b0;
      chk("ll_b_active", ifb.active, 3'b000);
      chk("ll_b_x", ifb.bullet_x, 0);
      chk("ll_b_y", ifb.bullet_y, 0);
      chk("ll_b_launched", ifb.launched, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
